circuit5_operand_driver: RTL and testbench



---
 rtl/circuit5_operand_driver.sv | 147 ++++++++++++++
 tb/tb_circuit5_operand_driver.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circuit5_operand_driver.sv
// circuit5_operand_driver
//
// Handshaked wrapper stage for the circuit5 datapath. One operand set is
// accepted at a time, registered onto the circuit5 inputs and held there.
// The stage waits LATENCY clock edges, captures circuit5's z result and
// presents it on a valid/ready output port until it is consumed.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready depends only on the FSM state and
// never on out_ready. out_valid/out_z stay stable until the transfer edge.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready      operand-side handshake
//   in_a..in_d, in_zero      operand set
//   c5_a..c5_d, c5_zero      registered operands driven into circuit5
//   c5_z                     result coming back from circuit5
//   out_valid / out_ready    result-side handshake
//   out_z                    captured result
//   busy                     high whenever the FSM is not idle
//   txn_count                completed output handshakes (wraps silently)
module circuit5_operand_driver #(
  parameter int DATAWIDTH = 64,
  parameter int LATENCY   = 2,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_a,
  input  logic [DATAWIDTH-1:0] in_b,
  input  logic [DATAWIDTH-1:0] in_c,
  input  logic [DATAWIDTH-1:0] in_d,
  input  logic [DATAWIDTH-1:0] in_zero,
  output logic [DATAWIDTH-1:0] c5_a,
  output logic [DATAWIDTH-1:0] c5_b,
  output logic [DATAWIDTH-1:0] c5_c,
  output logic [DATAWIDTH-1:0] c5_d,
  output logic [DATAWIDTH-1:0] c5_zero,
  input  logic [DATAWIDTH-1:0] c5_z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_z,
  output logic                 busy,
  output logic [CNTWIDTH-1:0]  txn_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_t;

  // LATENCY is limited to 1..255, so an 8-bit wait counter always suffices.
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATAWIDTH-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, zero_q, zero_d;
  logic [DATAWIDTH-1:0]  out_z_q, out_z_d;
  logic                  out_valid_q, out_valid_d;
  logic [CNTWIDTH-1:0]   txn_count_q, txn_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      zero_q      <= '0;
      out_z_q     <= '0;
      out_valid_q <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      zero_q      <= zero_d;
      out_z_q     <= out_z_d;
      out_valid_q <= out_valid_d;
      txn_count_q <= txn_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    zero_d      = zero_q;
    out_z_d     = out_z_q;
    out_valid_d = out_valid_q;
    txn_count_d = txn_count_q;

    case (state_q)
      IDLE: begin
        // in_ready is high in IDLE, so in_valid alone completes the transfer.
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          c_d     = in_c;
          d_d     = in_d;
          zero_d  = in_zero;
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        // cnt==1 marks the edge exactly LATENCY edges after the accept edge.
        if (cnt_q == 8'd1) begin
          out_z_d     = c5_z;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          txn_count_d = txn_count_q + CNTWIDTH'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign c5_a      = a_q;
  assign c5_b      = b_q;
  assign c5_c      = c_q;
  assign c5_d      = d_q;
  assign c5_zero   = zero_q;
  assign out_z     = out_z_q;
  assign out_valid = out_valid_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_circuit5_operand_driver.sv
// Testbench for circuit5_operand_driver. Three instances share clock, reset
// and operand buses; each has its own valid/ready signals:
//   inst 0: LATENCY=2, CNTWIDTH=16 (main directed sequence)
//   inst 1: LATENCY=5, CNTWIDTH=2  (latency check and counter wrap)
//   inst 2: LATENCY=1, CNTWIDTH=2  (minimum latency, modular sum)
// Each instance drives a circuit5 stand-in: z = a+b+c+d+zero, combinational
// sum followed by LATENCY-1 registers, so z is valid for sampling exactly
// LATENCY edges after the operands appear.
module tb_circuit5_operand_driver;

  localparam int W = 64;

  logic clk;
  logic rst;
  logic [W-1:0] in_a, in_b, in_c, in_d, in_zero;

  logic         in_valid  [3];
  logic         out_ready [3];
  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic         busy_w      [3];
  logic [W-1:0] out_z_w     [3];
  logic [W-1:0] c5_a_w [3], c5_b_w [3], c5_c_w [3], c5_d_w [3], c5_zero_w [3];
  logic [W-1:0] c5_z_w [3];
  logic [15:0]  tc0;
  logic [1:0]   tc1, tc2;

  logic [W-1:0] exp_q[$];
  int n_pass;
  int n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // circuit5 stand-ins
  logic [W-1:0] sum_w [3];
  logic [W-1:0] p0;
  logic [W-1:0] p1 [4];
  always_comb begin
    for (int k = 0; k < 3; k++)
      sum_w[k] = c5_a_w[k] + c5_b_w[k] + c5_c_w[k] + c5_d_w[k] + c5_zero_w[k];
  end
  always @(posedge clk) begin
    p0    <= sum_w[0];
    p1[0] <= sum_w[1];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
    p1[3] <= p1[2];
  end
  assign c5_z_w[0] = p0;
  assign c5_z_w[1] = p1[3];
  assign c5_z_w[2] = sum_w[2];

  circuit5_operand_driver #(.DATAWIDTH(W), .LATENCY(2), .CNTWIDTH(16)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_zero(in_zero),
    .c5_a(c5_a_w[0]), .c5_b(c5_b_w[0]), .c5_c(c5_c_w[0]), .c5_d(c5_d_w[0]),
    .c5_zero(c5_zero_w[0]), .c5_z(c5_z_w[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready[0]), .out_z(out_z_w[0]), .busy(busy_w[0]), .txn_count(tc0)
  );

  circuit5_operand_driver #(.DATAWIDTH(W), .LATENCY(5), .CNTWIDTH(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_zero(in_zero),
    .c5_a(c5_a_w[1]), .c5_b(c5_b_w[1]), .c5_c(c5_c_w[1]), .c5_d(c5_d_w[1]),
    .c5_zero(c5_zero_w[1]), .c5_z(c5_z_w[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready[1]), .out_z(out_z_w[1]), .busy(busy_w[1]), .txn_count(tc1)
  );

  circuit5_operand_driver #(.DATAWIDTH(W), .LATENCY(1), .CNTWIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_zero(in_zero),
    .c5_a(c5_a_w[2]), .c5_b(c5_b_w[2]), .c5_c(c5_c_w[2]), .c5_d(c5_d_w[2]),
    .c5_zero(c5_zero_w[2]), .c5_z(c5_z_w[2]), .out_valid(out_valid_w[2]),
    .out_ready(out_ready[2]), .out_z(out_z_w[2]), .busy(busy_w[2]), .txn_count(tc2)
  );

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops(input logic [W-1:0] a, b, c, d, z);
    in_a = a; in_b = b; in_c = c; in_d = d; in_zero = z;
  endtask

  // Present an operand set on instance k and return just after its accept edge.
  task automatic do_accept(input int k, input logic [W-1:0] a, b, c, d, z);
    int n;
    drive_ops(a, b, c, d, z);
    in_valid[k] = 1'b1;
    n = 0;
    while (!in_ready_w[k] && n < 50) begin
      step();
      n++;
    end
    if (!in_ready_w[k]) check("accept_timeout", 64'(in_ready_w[k]), 64'd1);
    exp_q.push_back(a + b + c + d + z);
    step();
    in_valid[k] = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic wait_out(input int k, output int lat);
    lat = 1;
    while (!out_valid_w[k] && lat < 300) begin
      step();
      lat++;
    end
    lat--;
    if (!out_valid_w[k]) check("out_valid_timeout", 64'(out_valid_w[k]), 64'd1);
  endtask

  task automatic pop_check(input int k, input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_no_expected"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, out_z_w[k], e);
    end
  endtask

  task automatic handshake(input int k);
    out_ready[k] = 1'b1;
    step();
    out_ready[k] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int lat;
    int cyc;
    int n_acc;
    int n_res;
    int acc_cyc [2];
    logic acc;
    logic hs;
    logic seen;
    int exp_tc [4];

    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
    end
    drive_ops('0, '0, '0, '0, '0);

    // 1. asynchronous reset, asserted between edges
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid_w[0]), 64'd0);
    check("rst_out_z", out_z_w[0], 64'd0);
    check("rst_c5_a", c5_a_w[0], 64'd0);
    check("rst_c5_zero", c5_zero_w[0], 64'd0);
    check("rst_txn", 64'(tc0), 64'd0);
    check("rst_busy", 64'(busy_w[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", 64'(in_ready_w[0]), 64'd1);

    // 2. single transaction, out_ready high throughout
    out_ready[0] = 1'b1;
    do_accept(0, 64'd1, 64'd1, 64'd1, 64'd1, 64'd1);
    check("single_c5_a", c5_a_w[0], 64'd1);
    check("single_c5_zero", c5_zero_w[0], 64'd1);
    check("single_busy", 64'(busy_w[0]), 64'd1);
    check("single_in_ready_low", 64'(in_ready_w[0]), 64'd0);
    wait_out(0, lat);
    check("single_latency", 64'(lat), 64'd2);
    pop_check(0, "single_z");
    step();
    out_ready[0] = 1'b0;
    check("single_out_valid_drop", 64'(out_valid_w[0]), 64'd0);
    check("single_txn", 64'(tc0), 64'd1);
    check("single_in_ready", 64'(in_ready_w[0]), 64'd1);

    // 3. backpressure; a second operand set offered meanwhile is ignored
    do_accept(0, 64'd100, 64'd10, 64'd8, 64'd4, 64'd0);
    wait_out(0, lat);
    check("bp_latency", 64'(lat), 64'd2);
    drive_ops(64'd7, 64'd7, 64'd7, 64'd7, 64'd7);
    in_valid[0] = 1'b1;
    seen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid_w[0] || out_z_w[0] !== 64'd122 || in_ready_w[0]) seen = 1'b0;
      step();
    end
    check("bp_hold", 64'(seen), 64'd1);
    check("bp_c5_a_kept", c5_a_w[0], 64'd100);
    check("bp_in_ready_low", 64'(in_ready_w[0]), 64'd0);
    in_valid[0] = 1'b0;
    pop_check(0, "bp_z");
    handshake(0);
    check("bp_txn", 64'(tc0), 64'd2);
    check("bp_out_valid_drop", 64'(out_valid_w[0]), 64'd0);
    check("bp_c5_a_after", c5_a_w[0], 64'd100);

    // 4. back-to-back with in_valid held high
    drive_ops(64'd1, 64'd1, 64'd1, 64'd1, 64'd1);
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    n_acc = 0;
    n_res = 0;
    cyc = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    while (n_res < 2 && cyc < 40) begin
      acc = in_valid[0] && in_ready_w[0];
      hs  = out_valid_w[0] && out_ready[0];
      if (hs) begin
        pop_check(0, "b2b_z");
        n_res++;
      end
      if (acc) exp_q.push_back(in_a + in_b + in_c + in_d + in_zero);
      step();
      cyc++;
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) drive_ops(64'd100, 64'd10, 64'd8, 64'd4, 64'd0);
        else in_valid[0] = 1'b0;
      end
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    check("b2b_results", 64'(n_res), 64'd2);
    check("b2b_accept_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);
    check("b2b_txn", 64'(tc0), 64'd4);

    // 5. reset one cycle after accept discards the in-flight result
    do_accept(0, 64'd2, 64'd2, 64'd2, 64'd2, 64'd2);
    step();
    rst = 1'b1;
    #1;
    check("midrst_c5_a", c5_a_w[0], 64'd0);
    check("midrst_busy", 64'(busy_w[0]), 64'd0);
    check("midrst_txn", 64'(tc0), 64'd0);
    #2 rst = 1'b0;
    void'(exp_q.pop_front());
    out_ready[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid_w[0]) seen = 1'b1;
      step();
    end
    out_ready[0] = 1'b0;
    check("midrst_no_out_valid", 64'(seen), 64'd0);
    check("midrst_txn_after", 64'(tc0), 64'd0);
    do_accept(0, 64'd3, 64'd0, 64'd0, 64'd0, 64'd0);
    wait_out(0, lat);
    check("midrst_next_latency", 64'(lat), 64'd2);
    pop_check(0, "midrst_next_z");
    handshake(0);
    check("midrst_next_txn", 64'(tc0), 64'd1);

    // 6a. LATENCY=5 and 2-bit counter wrap
    exp_tc = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      do_accept(1, 64'(i + 1), 64'd10, 64'(i * 3), 64'd0, 64'd5);
      wait_out(1, lat);
      check("lat5_latency", 64'(lat), 64'd5);
      pop_check(1, "lat5_z");
      handshake(1);
      check("lat5_txn", 64'(tc1), 64'(exp_tc[i]));
    end

    // 6b. LATENCY=1, sum wraps modulo 2^64
    do_accept(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0, 64'd0);
    wait_out(2, lat);
    check("lat1_latency", 64'(lat), 64'd1);
    pop_check(2, "lat1_z_wrap");
    handshake(2);
    for (int i = 0; i < 2; i++) begin
      do_accept(2, 64'($urandom_range(1000, 0)), 64'($urandom_range(1000, 0)),
                64'($urandom_range(1000, 0)), 64'($urandom), 64'($urandom));
      wait_out(2, lat);
      check("lat1_latency_rand", 64'(lat), 64'd1);
      pop_check(2, "lat1_z_rand");
      handshake(2);
    end
    check("lat1_txn", 64'(tc2), 64'd3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
